// File: rtl/uart_packet_loader.sv
// rtl/uart_packet_loader.sv - frames UART bytes (A5 CMD ADDR[4] LEN[2] DATA CSUM) into byte memory writes
// Optional ACK/NAK reply over UART TX when UART_LOADER_ACK_EN is defined.
module uart_packet_loader #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          TIMEOUT_CLKS = 86800,
  parameter logic [7:0]  CMD_WRITE    = 8'h01
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
`ifdef UART_LOADER_ACK_EN
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
`endif
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Mem_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [7:0]            o_Mem_Data,
  input  logic                  i_Mem_Ready,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Error,
  output logic [1:0]            o_Error_Code
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DRAIN
  } state_t;

  state_t                  state, state_nxt;
  logic [1:0]              byte_idx;
  logic [31:0]             addr_sh;
  logic [7:0]              len_lo;
  logic [15:0]             remaining;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [7:0]              sum;
  logic [TW-1:0]           timer;

  logic                    err_fire, done_fire, wr_fire, accept, timeout;
  logic [1:0]              err_code_nxt;

  assign accept  = o_Mem_Wr_En && i_Mem_Ready;
  assign timeout = (state != S_IDLE) && !i_Rx_DV && (timer == TIMER_LAST);
  assign o_Busy  = (state != S_IDLE);

  always_comb begin
    state_nxt    = state;
    err_fire     = 1'b0;
    err_code_nxt = o_Error_Code;
    done_fire    = 1'b0;
    wr_fire      = 1'b0;
    case (state)
      S_IDLE:
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_nxt = S_CMD;
      S_CMD:
        if (i_Rx_DV) begin
          if (i_Rx_Byte == CMD_WRITE) begin
            state_nxt = S_ADDR;
          end else begin
            err_fire     = 1'b1;
            err_code_nxt = 2'b00;
          end
        end
      S_ADDR:
        if (i_Rx_DV && byte_idx == 2'd3) state_nxt = S_LEN;
      S_LEN:
        if (i_Rx_DV && byte_idx == 2'd1)
          state_nxt = ({i_Rx_Byte, len_lo} == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:
        if (i_Rx_DV) begin
          // a byte landing on the acceptance edge is fine; only a stalled write overruns
          if (o_Mem_Wr_En && !i_Mem_Ready) begin
            err_fire     = 1'b1;
            err_code_nxt = 2'b11;
          end else begin
            wr_fire = 1'b1;
            if (remaining == 16'd1) state_nxt = S_CSUM;
          end
        end
      S_CSUM:
        if (i_Rx_DV) state_nxt = S_DRAIN;
      S_DRAIN:
        if (!o_Mem_Wr_En || i_Mem_Ready) begin
          if (sum == 8'h00) begin
            done_fire = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            err_fire     = 1'b1;
            err_code_nxt = 2'b10;
          end
        end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout && !done_fire && !err_fire) begin
      err_fire     = 1'b1;
      err_code_nxt = 2'b01;
    end
    if (err_fire) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state        <= S_IDLE;
      byte_idx     <= '0;
      addr_sh      <= '0;
      len_lo       <= '0;
      remaining    <= '0;
      ptr          <= '0;
      sum          <= '0;
      timer        <= '0;
      o_Mem_Wr_En  <= 1'b0;
      o_Mem_Addr   <= '0;
      o_Mem_Data   <= '0;
      o_Done       <= 1'b0;
      o_Error      <= 1'b0;
      o_Error_Code <= 2'b00;
    end else begin
      state   <= state_nxt;
      o_Done  <= done_fire;
      o_Error <= err_fire;
      if (err_fire) o_Error_Code <= err_code_nxt;

      if (i_Rx_DV || state_nxt == S_IDLE) timer <= '0;
      else                                timer <= timer + 1'b1;

      if (state_nxt != state)                            byte_idx <= '0;
      else if (i_Rx_DV && (state == S_ADDR || state == S_LEN)) byte_idx <= byte_idx + 1'b1;

      // SYNC is excluded from the sum; everything from CMD through CSUM is included
      if (state == S_IDLE)  sum <= '0;
      else if (i_Rx_DV && state != S_DRAIN) sum <= sum + i_Rx_Byte;

      if (i_Rx_DV && state == S_ADDR) addr_sh <= {i_Rx_Byte, addr_sh[31:8]};
      if (i_Rx_DV && state == S_LEN) begin
        if (byte_idx == 2'd0) len_lo    <= i_Rx_Byte;
        else                  remaining <= {i_Rx_Byte, len_lo};
      end

      if (state == S_LEN) ptr <= addr_sh[ADDR_WIDTH-1:0];
      else if (wr_fire)   ptr <= ptr + 1'b1;
      if (wr_fire) remaining <= remaining - 16'd1;

      if (err_fire) begin
        o_Mem_Wr_En <= 1'b0;
      end else if (wr_fire) begin
        o_Mem_Wr_En <= 1'b1;
        o_Mem_Addr  <= ptr;
        o_Mem_Data  <= i_Rx_Byte;
      end else if (accept) begin
        o_Mem_Wr_En <= 1'b0;
      end
    end
  end

`ifdef UART_LOADER_ACK_EN
  logic       resp_pending;
  logic [7:0] resp_byte;

  // one-deep response slot; a newer status overwrites an unsent one
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      resp_pending <= 1'b0;
      resp_byte    <= '0;
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= '0;
    end else begin
      o_Tx_DV <= 1'b0;
      if (o_Done || o_Error) begin
        resp_pending <= 1'b1;
        resp_byte    <= o_Done ? 8'h06 : 8'h15;
      end else if (resp_pending && !i_Tx_Active && !o_Tx_DV) begin
        o_Tx_DV      <= 1'b1;
        o_Tx_Byte    <= resp_byte;
        resp_pending <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_packet_loader.sv
// tb/tb_uart_packet_loader.sv - directed checks of uart_packet_loader framing, writes and errors
module tb_uart_packet_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        mem_ready = 1'b1;
  logic        wr_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy, done, error;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [31:0] wq_addr[$];
  logic [7:0]  wq_data[$];

  always #5 clk = ~clk;

  uart_packet_loader #(.ADDR_WIDTH(32), .TIMEOUT_CLKS(200), .CMD_WRITE(8'h01)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Mem_Wr_En(wr_en), .o_Mem_Addr(mem_addr), .o_Mem_Data(mem_data),
    .i_Mem_Ready(mem_ready),
    .o_Busy(busy), .o_Done(done), .o_Error(error), .o_Error_Code(err_code)
  );

  // sample between drive (negedge) and the next active edge
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (wr_en && mem_ready) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_data);
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[], input int n);
    for (int i = 0; i < n; i++) send_byte(s[i]);
  endtask

  initial begin
    logic [7:0] f[];
    int wb, db, eb, k;

    repeat (2) @(negedge clk);
    check_eq("reset_outputs", {wr_en, mem_addr, mem_data, busy, done, error, err_code}, 64'd0);
    rst_n = 1'b1;

    // 1: good frame, two payload writes
    wb = wq_addr.size(); db = done_cnt; eb = err_cnt;
    f = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'hAA, 8'h55, 8'hEE};
    send_seq(f, 11);
    repeat (4) @(negedge clk);
    check_eq("t1_nwrites", wq_addr.size() - wb, 2);
    check_eq("t1_w0", {wq_addr[wb], wq_data[wb]}, {32'h10, 8'hAA});
    check_eq("t1_w1", {wq_addr[wb+1], wq_data[wb+1]}, {32'h11, 8'h55});
    check_eq("t1_done", done_cnt - db, 1);
    check_eq("t1_noerr", err_cnt - eb, 0);
    check_eq("t1_busy", busy, 0);

    // 2: bad checksum, writes still happen
    wb = wq_addr.size(); db = done_cnt; eb = err_cnt;
    f[10] = 8'hEF;
    send_seq(f, 11);
    repeat (4) @(negedge clk);
    check_eq("t2_nwrites", wq_addr.size() - wb, 2);
    check_eq("t2_w1", {wq_addr[wb+1], wq_data[wb+1]}, {32'h11, 8'h55});
    check_eq("t2_err", err_cnt - eb, 1);
    check_eq("t2_code", err_code, 2'b10);
    check_eq("t2_nodone", done_cnt - db, 0);

    // 3: bad CMD, trailing bytes ignored
    wb = wq_addr.size(); db = done_cnt; eb = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    check_eq("t3_err_pulse", error, 1);
    check_eq("t3_code", err_code, 2'b00);
    f = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h33};
    send_seq(f, 8);
    repeat (3) @(negedge clk);
    check_eq("t3_idle", busy, 0);
    check_eq("t3_one_err", err_cnt - eb, 1);
    check_eq("t3_nowrites", wq_addr.size() - wb, 0);

    // 4: inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    k = 0;
    while (!error && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_timeout_cycles", k, 200);
    check_eq("t4_code", err_code, 2'b01);
    @(negedge clk);
    check_eq("t4_idle", busy, 0);

    // 5: stalled write then another byte -> overrun
    wb = wq_addr.size();
    mem_ready = 1'b0;
    f = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11};
    send_seq(f, 9);
    check_eq("t5_wr_first", {wr_en, mem_addr, mem_data}, {1'b1, 32'h20, 8'h11});
    repeat (3) @(negedge clk);
    check_eq("t5_wr_held", {wr_en, mem_addr, mem_data}, {1'b1, 32'h20, 8'h11});
    send_byte(8'h22);
    check_eq("t5_err_pulse", error, 1);
    check_eq("t5_code", err_code, 2'b11);
    check_eq("t5_wr_dropped", wr_en, 0);
    check_eq("t5_nowrites", wq_addr.size() - wb, 0);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    // 6: address wrap, then reset mid-payload
    wb = wq_addr.size(); db = done_cnt; eb = err_cnt;
    f = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h11, 8'h22};
    send_seq(f, 10);
    @(negedge clk);
    check_eq("t6_nwrites", wq_addr.size() - wb, 2);
    check_eq("t6_w0", {wq_addr[wb], wq_data[wb]}, {32'hFFFFFFFF, 8'h11});
    check_eq("t6_w1", {wq_addr[wb+1], wq_data[wb+1]}, {32'h00000000, 8'h22});
    check_eq("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_reset_outputs", {wr_en, mem_addr, mem_data, busy, done, error, err_code}, 64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t6_no_status", (done_cnt - db) + (err_cnt - eb), 0);
    check_eq("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
